// File: rtl/seven_seg_scan_mux.sv
// N-digit time-multiplexed seven-segment driver with blanking dead-time, per-digit enable,
// leading-zero suppression, decimal points and a frame-coherent input snapshot.
module seven_seg_scan_mux #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned ON_CYCLES    = 24000,
   parameter int unsigned BLANK_CYCLES = 240
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [4*NUM_DIGITS-1:0]       digits_i,
   input  logic [NUM_DIGITS-1:0]         dp_in_i,
   input  logic [NUM_DIGITS-1:0]         digit_en_i,
   input  logic                          lz_suppress_i,
   output logic [6:0]                    seg_o,
   output logic                          dp_o,
   output logic [NUM_DIGITS-1:0]         select_o,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
   output logic                          frame_tick_o
);

   localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
   localparam int unsigned CntMax = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam bit          HasBlank = (BLANK_CYCLES != 0);

   localparam logic [CntW-1:0] OnLast    = CntW'(ON_CYCLES - 1);
   localparam logic [CntW-1:0] BlankLast = HasBlank ? CntW'(BLANK_CYCLES - 1) : '0;
   localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

   typedef enum logic {StBlank, StOn} state_e;

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic                    primed_q;
   logic                    capture;

   logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
   logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
   logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
   logic                    snap_lz_q, snap_lz_d;

   logic [NUM_DIGITS-1:0]   sel_q, sel_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic                    tick_q;

   logic [NUM_DIGITS-1:0]   supp;
   logic                    run;
   logic [3:0]              nib;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // The first edge after reset only primes the snapshot; the frame starts right after it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      capture = 1'b0;
      if (!primed_q) begin
         capture = 1'b1;
         state_d = HasBlank ? StBlank : StOn;
         cnt_d   = '0;
      end else begin
         case (state_q)
            StBlank: begin
               if (cnt_q == BlankLast) begin
                  state_d = StOn;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StOn: begin
               if (cnt_q == OnLast) begin
                  state_d = HasBlank ? StBlank : StOn;
                  cnt_d   = '0;
                  if (idx_q == IdxLast) begin
                     idx_d   = '0;
                     capture = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = StBlank;
         endcase
      end
   end

   always_comb begin
      snap_dig_d = snap_dig_q;
      snap_dp_d  = snap_dp_q;
      snap_en_d  = snap_en_q;
      snap_lz_d  = snap_lz_q;
      if (capture) begin
         snap_dig_d = digits_i;
         snap_dp_d  = dp_in_i;
         snap_en_d  = digit_en_i;
         snap_lz_d  = lz_suppress_i;
      end
   end

   // Outputs are computed from next-state values so the registered pins line up with the slot.
   always_comb begin
      supp = '0;
      run  = snap_lz_d;
      for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
         if (snap_en_d[i] && (snap_dig_d[4*i +: 4] != 4'h0)) run = 1'b0;
         supp[i] = run;
      end
      nib   = snap_dig_d[{idx_d, 2'b00} +: 4];
      sel_d = '1;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
      if (state_d == StOn && snap_en_d[idx_d]) begin
         sel_d[idx_d] = 1'b0;
         dp_d         = ~snap_dp_d[idx_d];
         if (!supp[idx_d]) seg_d = hex_to_seg(nib);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= StBlank;
         cnt_q      <= '0;
         idx_q      <= '0;
         primed_q   <= 1'b0;
         snap_dig_q <= '0;
         snap_dp_q  <= '0;
         snap_en_q  <= '0;
         snap_lz_q  <= 1'b0;
         sel_q      <= '1;
         seg_q      <= 7'b1111111;
         dp_q       <= 1'b1;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         primed_q   <= 1'b1;
         snap_dig_q <= snap_dig_d;
         snap_dp_q  <= snap_dp_d;
         snap_en_q  <= snap_en_d;
         snap_lz_q  <= snap_lz_d;
         sel_q      <= sel_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         tick_q     <= capture;
      end
   end

   assign seg_o        = seg_q;
   assign dp_o         = dp_q;
   assign select_o     = sel_q;
   assign digit_idx_o  = idx_q;
   assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Drives three differently-parameterised scan muxes from shared stimulus and compares every
// output, every cycle, against a frame-position reference model.
module tb_seven_seg_scan_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] digits;
   logic [7:0]  dp_in;
   logic [7:0]  en;
   logic        lz;

   always #5 clk = ~clk;

   logic [3:0] d0_sel, d1_sel;
   logic [7:0] d2_sel;
   logic [6:0] d0_seg, d1_seg, d2_seg;
   logic       d0_dp, d1_dp, d2_dp;
   logic [1:0] d0_idx, d1_idx;
   logic [2:0] d2_idx;
   logic       d0_tick, d1_tick, d2_tick;

   seven_seg_scan_mux #(.NUM_DIGITS(4), .ON_CYCLES(4), .BLANK_CYCLES(2)) dut0 (
      .clk_i(clk), .reset_i(rst), .digits_i(digits[15:0]), .dp_in_i(dp_in[3:0]),
      .digit_en_i(en[3:0]), .lz_suppress_i(lz), .seg_o(d0_seg), .dp_o(d0_dp),
      .select_o(d0_sel), .digit_idx_o(d0_idx), .frame_tick_o(d0_tick)
   );

   seven_seg_scan_mux #(.NUM_DIGITS(4), .ON_CYCLES(4), .BLANK_CYCLES(0)) dut1 (
      .clk_i(clk), .reset_i(rst), .digits_i(digits[15:0]), .dp_in_i(dp_in[3:0]),
      .digit_en_i(en[3:0]), .lz_suppress_i(lz), .seg_o(d1_seg), .dp_o(d1_dp),
      .select_o(d1_sel), .digit_idx_o(d1_idx), .frame_tick_o(d1_tick)
   );

   seven_seg_scan_mux #(.NUM_DIGITS(8), .ON_CYCLES(2), .BLANK_CYCLES(1)) dut2 (
      .clk_i(clk), .reset_i(rst), .digits_i(digits), .dp_in_i(dp_in),
      .digit_en_i(en), .lz_suppress_i(lz), .seg_o(d2_seg), .dp_o(d2_dp),
      .select_o(d2_sel), .digit_idx_o(d2_idx), .frame_tick_o(d2_tick)
   );

   logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   int pn [3] = '{4, 4, 8};
   int po [3] = '{4, 4, 2};
   int pb [3] = '{2, 0, 1};

   // Model state: position in frame (-1 = idle after reset) and the snapshot it captured.
   int          pos [3] = '{-1, -1, -1};
   logic [31:0] sd  [3];
   logic [7:0]  sdp [3];
   logic [7:0]  sen [3];
   logic        slz [3];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_dut(input int k, input logic [7:0] sel, input logic [6:0] seg,
                            input logic dp, input int idx, input logic tick);
      logic [7:0]  esel = 8'hFF;
      logic [6:0]  eseg = 7'h7F;
      logic        edp  = 1'b1;
      int          eidx = 0;
      logic        etick = 1'b0;
      logic [31:0] d = sd[k];
      logic [7:0]  e = sen[k];
      logic [7:0]  p = sdp[k];
      string       nm = $sformatf("dut%0d", k);
      if (pos[k] >= 0) begin
         int  slot = pos[k] / (pb[k] + po[k]);
         bit  on   = (pos[k] % (pb[k] + po[k])) >= pb[k];
         bit  blank;
         eidx  = slot;
         etick = (pos[k] == 0);
         if (on && e[slot]) begin
            esel[slot] = 1'b0;
            edp        = ~p[slot];
            blank      = slz[k] && (slot != 0);
            for (int j = slot; j < pn[k]; j++)
               if (e[j] && d[4*j +: 4] != 4'h0) blank = 1'b0;
            if (!blank) eseg = tbl[d[4*slot +: 4]];
         end
      end
      chk({nm, ".select"}, 32'(sel), 32'(esel));
      chk({nm, ".seg"}, 32'(seg), 32'(eseg));
      chk({nm, ".dp"}, 32'(dp), 32'(edp));
      chk({nm, ".digit_idx"}, 32'(idx), 32'(eidx));
      chk({nm, ".frame_tick"}, 32'(tick), 32'(etick));
      chk({nm, ".one_low"}, 32'($countones(~sel) <= 1), 32'd1);
   endtask

   task automatic step();
      for (int k = 0; k < 3; k++) begin
         if (rst) pos[k] = -1;
         else begin
            pos[k] = (pos[k] + 1) % (pn[k] * (pb[k] + po[k]));
            if (pos[k] == 0) begin
               sd[k] = digits; sdp[k] = dp_in; sen[k] = en; slz[k] = lz;
            end
         end
      end
      @(posedge clk);
      #1;
      check_dut(0, {4'hF, d0_sel}, d0_seg, d0_dp, int'(d0_idx), d0_tick);
      check_dut(1, {4'hF, d1_sel}, d1_seg, d1_dp, int'(d1_idx), d1_tick);
      check_dut(2, d2_sel, d2_seg, d2_dp, int'(d2_idx), d2_tick);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst = 1'b1; digits = 32'h8765_1234; dp_in = 8'h00; en = 8'hFF; lz = 1'b0;
      run(3);
      rst = 1'b0;
      run(30);
      digits = 32'h1357_ABCD;
      run(48);
      digits = 32'h0000_0030; lz = 1'b1;
      run(48);
      digits = 32'h0000_0000;
      run(48);
      digits = 32'h9000_1234; lz = 1'b0; en = 8'b1111_1011; dp_in = 8'b0000_0100;
      run(48);
      en = 8'hFF; dp_in = 8'hA5;
      run(24);
      for (int r = 0; r < 25; r++) begin
         digits = $urandom >> (4 * $urandom_range(0, 7));
         dp_in  = 8'($urandom);
         en     = 8'($urandom) | 8'($urandom);
         lz     = 1'($urandom_range(0, 1));
         run($urandom_range(1, 30));
      end
      digits = 32'h4321_5678; en = 8'hFF; dp_in = 8'h0F; lz = 1'b0;
      begin
         int  t = 0;
         while (t < 40 && !(pos[0] >= 0 && pos[0] / 6 == 2 && pos[0] % 6 >= 2)) begin
            step();
            t++;
         end
         chk("reach_digit2_on", 32'(pos[0] >= 0 && pos[0] / 6 == 2), 32'd1);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      run(60);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_mux.md
Name: seven_seg_scan_mux

Overview:
Parametrised N-digit time-multiplexed seven-segment driver. It is the successor to the 2-digit toggle mux: it adds a configurable refresh rate, anti-ghosting blanking between digits, a per-digit enable, leading-zero suppression, decimal points and a frame-coherent input snapshot. It contains its own hex decoder. It sits between datapath registers and the board's PNP digit drivers and shared segment lines.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
ON_CYCLES, 24000, clk cycles each digit is powered per slot (>=1)
BLANK_CYCLES, 240, dead-time cycles before each slot, with all digits off and segments off (>=0; 0 = no blanking)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
digits  in  4*NUM_DIGITS  hex nibbles; digit i = digits[4i+3:4i]; digit 0 = rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit, active-high
digit_en  in  NUM_DIGITS  per-digit enable, active-high
lz_suppress  in  1  1 = blank leading zero digits
seg  out  7  active-low segments, seg[6:0] = {g,f,e,d,c,b,a}
dp  out  1  active-low decimal point
select  out  NUM_DIGITS  active-low digit power (PNP); at most one bit low at any time
digit_idx  out  clog2(NUM_DIGITS)  index of the current slot
frame_tick  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Clock and reset: single clock domain; every output is registered.
- Reset: state=BLANK, digit_idx=0, counter=0, select all 1s, seg=7'b1111111, dp=1, frame_tick=0, snapshot=0.
- Slot FSM, states BLANK and ON:
  - BLANK: select all 1s, seg/dp all 1s. Stays BLANKING_CYCLES cycles, then moves to ON with counter=0.
  - ON: select[digit_idx]=0 unless the digit is disabled; seg/dp per the rules below. Stays ON_CYCLES cycles.
  - At the end of ON: digit_idx increments, wrapping NUM_DIGITS-1 -> 0, and the FSM returns to BLANK.
  - If BLANK_CYCLES=0, BLANK is skipped and ON slots run back to back.
- Frame period is exactly NUM_DIGITS*(BLANK_CYCLES+ON_CYCLES) cycles.
- Snapshot:
  - digits, dp_in, digit_en and lz_suppress are captured into internal registers on the first clock edge after reset deasserts.
  - They are captured again on the edge ending the last ON cycle of digit NUM_DIGITS-1.
  - frame_tick is high for the one cycle following each capture.
  - Input changes mid-frame have no visible effect until the next capture, so there is no tearing.
- Disabled digit (snapshot digit_en[i]=0): the slot is still timed, so brightness stays uniform. select stays all 1s, seg and dp blank.
- Leading-zero suppression (snapshot lz_suppress=1):
  - Scanning from digit NUM_DIGITS-1 downward, each digit with value 0 is blanked (seg=7'b1111111) until the first nonzero digit.
  - Digit 0 is never suppressed.
  - A suppressed digit still drives select low and still shows dp if requested.
  - Disabled digits count as zero for the suppression scan.
- Decoder (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- dp = ~snapshot dp_in[digit_idx] during ON of an enabled digit; otherwise 1.
- Reset mid-slot: takes effect on the next edge, and all outputs return to reset values the following cycle. After release, the first visible slot is digit 0, preceded by BLANK.
- Invariant: no cycle has more than one select bit low, and select is never low during BLANK.

Test Plan:
- NUM_DIGITS=4, ON=4, BLANK=2, all enabled, digits=16'h1234, lz=0.
  - Required: repeating 24-cycle frame; 2 cycles all-off, then select=1110 for 4 cycles with seg=0010000? — no: seg for digit 0 = '4' = 0011001.
  - Then select 1101 '3', 1011 '2', 0111 '1'.
  - frame_tick period is 24 cycles.
- Same configuration, change digits to 16'hABCD mid-frame.
  - Required: the remaining slots still show 1,2,3,4.
  - The new digits appear only after the next frame_tick; digit 0 shows d=0100001.
- digits=16'h0030, lz=1.
  - Required: digits 3 and 2 show select low with seg=1111111; digit 1 shows '3' (0110000); digit 0 shows '0' (1000000).
  - With digits=16'h0000, only digit 0 shows '0'.
- digit_en=4'b1011, dp_in=4'b0100.
  - Required: during digit 2's slot, select=1111 and dp=1 for the full 4 cycles; dp=0 is never seen.
  - Frame length is still 24 cycles.
- BLANK=0 and separately NUM_DIGITS=8.
  - Required: back-to-back slots with no all-off cycle, and digit_idx wraps 7->0.
  - Checker asserts at most one select bit low on every cycle of every run.
- Assert reset for one cycle during digit 2's ON slot.
  - Required: next cycle select=all 1s, seg=1111111, digit_idx=0.
  - After release: BLANK (2 cycles), then digit 0, with frame_tick one cycle after release.
